// File: rtl/uart_grid_bridge.sv
// Byte-command bridge between a UART byte link and a row-addressed grid engine:
// step with repeat count, row writes, clear, and '#'/'.' text dump of the grid.
module uart_grid_bridge #(
  parameter int COLS  = 8,
  parameter int ROWS  = 32,
  parameter int CNT_W = 8,
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [ROW_W-1:0] row_sel,
  input  logic [COLS-1:0]  row_rd_data,
  output logic [COLS-1:0]  row_wr_data,
  output logic             row_wr_en,
  output logic             step_en,
  input  logic             grid_busy,
  output logic             busy,
  output logic             rx_overrun
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [3:0] {
    IDLE, STEP, STEP_WAIT, DUMP_ADDR, DUMP_CELL, DUMP_CR, DUMP_LF, CLEAR, ECHO
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   steps_left;
  logic [ROW_W-1:0]   wr_row;
  logic [ROW_W-1:0]   row_ptr;
  logic [COL_W-1:0]   wr_col;
  logic [COL_W-1:0]   dump_col;
  logic [COLS-1:0]    write_buf;
  logic [COLS-1:0]    row_buf;
  logic [COLS-1:0]    cell_row;
  logic [1:0]         hold;
  logic               dump_after;
  logic               accept;
  logic               is_digit;
  logic [CNT_W+4:0]   count_next;
  logic [CNT_W-1:0]   count_sat;

  function automatic logic [7:0] cell_char(input logic bit_val);
    return bit_val ? 8'h23 : 8'h2E;
  endfunction

  assign busy = (state != IDLE) || tx_valid;

  // count*10+9 always fits in CNT_W+5 bits, so saturation is a single compare
  always_comb begin
    accept     = rx_valid && !busy;
    is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    count_next = ({5'b0, count} * (CNT_W + 5)'(10)) + {{(CNT_W + 1){1'b0}}, rx_data[3:0]};
    count_sat  = (count_next > (CNT_W + 5)'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : count_next[CNT_W-1:0];
    cell_row         = write_buf;
    cell_row[wr_col] = (rx_data == 8'h23);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      steps_left  <= '0;
      wr_row      <= '0;
      wr_col      <= '0;
      row_ptr     <= '0;
      dump_col    <= '0;
      write_buf   <= '0;
      row_buf     <= '0;
      hold        <= '0;
      dump_after  <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      row_sel     <= '0;
      row_wr_data <= '0;
      row_wr_en   <= 1'b0;
      step_en     <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      row_wr_en <= 1'b0;
      step_en   <= 1'b0;
      if (rx_valid && busy) rx_overrun <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          count <= is_digit ? count_sat : '0;
          if (!is_digit) begin
            case (rx_data)
              "s", "S": begin
                steps_left <= (count == '0) ? CNT_W'(1) : count;
                dump_after <= 1'b0;
                state      <= STEP;
              end
              "R": begin
                steps_left <= CNT_W'(1);
                dump_after <= 1'b1;
                state      <= STEP;
              end
              "r": begin
                row_ptr <= '0;
                row_sel <= '0;
                hold    <= 2'd1;
                state   <= DUMP_ADDR;
              end
              "w", "W": begin
                wr_row   <= '0;
                wr_col   <= '0;
                tx_data  <= "W";
                tx_valid <= 1'b1;
                state    <= ECHO;
              end
              ".", "#": begin
                write_buf <= cell_row;
                tx_data   <= rx_data;
                tx_valid  <= 1'b1;
                state     <= ECHO;
                if (wr_col == LAST_COL) begin
                  row_wr_en   <= 1'b1;
                  row_wr_data <= cell_row;
                  row_sel     <= wr_row;
                  wr_col      <= '0;
                  wr_row      <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
                end else begin
                  wr_col <= wr_col + 1'b1;
                end
              end
              "c", "C": begin
                row_ptr <= '0;
                state   <= CLEAR;
              end
              default: begin
                tx_data  <= "X";
                tx_valid <= 1'b1;
                state    <= ECHO;
              end
            endcase
          end
        end
        STEP: begin
          step_en    <= 1'b1;
          steps_left <= steps_left - 1'b1;
          hold       <= 2'd2;
          state      <= STEP_WAIT;
        end
        // The engine only raises grid_busy after it has seen step_en, so the
        // first cycles after the strobe are not trusted.
        STEP_WAIT: begin
          if (hold != 2'd0) begin
            hold <= hold - 1'b1;
          end else if (!grid_busy) begin
            if (steps_left != '0) begin
              state <= STEP;
            end else if (dump_after) begin
              row_ptr <= '0;
              row_sel <= '0;
              hold    <= 2'd1;
              state   <= DUMP_ADDR;
            end else begin
              tx_data  <= "S";
              tx_valid <= 1'b1;
              state    <= ECHO;
            end
          end
        end
        DUMP_ADDR: begin
          if (hold != 2'd0) begin
            hold <= hold - 1'b1;
          end else begin
            row_buf  <= row_rd_data;
            dump_col <= '0;
            tx_data  <= cell_char(row_rd_data[0]);
            tx_valid <= 1'b1;
            state    <= DUMP_CELL;
          end
        end
        DUMP_CELL: if (tx_ready) begin
          if (dump_col == LAST_COL) begin
            tx_data <= 8'h0D;
            state   <= DUMP_CR;
          end else begin
            dump_col <= dump_col + 1'b1;
            tx_data  <= cell_char(row_buf[dump_col + 1'b1]);
          end
        end
        DUMP_CR: if (tx_ready) begin
          tx_data <= 8'h0A;
          state   <= DUMP_LF;
        end
        DUMP_LF: if (tx_ready) begin
          tx_valid <= 1'b0;
          if (row_ptr == LAST_ROW) begin
            row_sel <= '0;
            state   <= IDLE;
          end else begin
            row_ptr <= row_ptr + 1'b1;
            row_sel <= row_ptr + 1'b1;
            hold    <= 2'd1;
            state   <= DUMP_ADDR;
          end
        end
        CLEAR: begin
          row_sel     <= row_ptr;
          row_wr_data <= '0;
          row_wr_en   <= 1'b1;
          if (row_ptr == LAST_ROW) begin
            wr_row   <= '0;
            wr_col   <= '0;
            tx_data  <= "C";
            tx_valid <= 1'b1;
            state    <= ECHO;
          end else begin
            row_ptr <= row_ptr + 1'b1;
          end
        end
        ECHO: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_grid_bridge.sv
// Directed bench for uart_grid_bridge: an 8x32 instance with a grid/engine model
// and a 13x5 instance for count saturation and write-row wrap.
module tb_uart_grid_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0] rx_data, tx_data, row_rd_data, row_wr_data;
  logic       rx_valid, tx_valid, tx_ready, row_wr_en, step_en, grid_busy, busy, rx_overrun;
  logic [4:0] row_sel;

  logic [7:0]  b_rx_data, b_tx_data;
  logic        b_rx_valid, b_tx_valid, b_tx_ready, b_row_wr_en, b_step_en, b_grid_busy, b_busy, b_rx_overrun;
  logic [2:0]  b_row_sel;
  logic [12:0] b_row_rd_data, b_row_wr_data;

  uart_grid_bridge #(.COLS(8), .ROWS(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .row_sel(row_sel), .row_rd_data(row_rd_data), .row_wr_data(row_wr_data),
    .row_wr_en(row_wr_en), .step_en(step_en), .grid_busy(grid_busy),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  uart_grid_bridge #(.COLS(13), .ROWS(5), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .row_sel(b_row_sel), .row_rd_data(b_row_rd_data), .row_wr_data(b_row_wr_data),
    .row_wr_en(b_row_wr_en), .step_en(b_step_en), .grid_busy(b_grid_busy),
    .busy(b_busy), .rx_overrun(b_rx_overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  logic ready_fixed, ready_random, rand_bit;
  assign tx_ready      = ready_random ? rand_bit : ready_fixed;
  assign b_tx_ready    = 1'b1;
  assign b_row_rd_data = '0;
  always @(negedge clk) rand_bit <= 1'($urandom_range(0, 1));

  // Grid memory with one-cycle read latency plus an engine busy for 3 cycles per step
  logic [7:0] grid [32];
  int busy_left = 0, b_busy_left = 0;
  assign grid_busy   = (busy_left != 0);
  assign b_grid_busy = (b_busy_left != 0);
  always @(posedge clk) begin
    if (row_wr_en) grid[row_sel] <= row_wr_data;
    row_rd_data <= grid[row_sel];
    if (rst)                busy_left <= 0;
    else if (step_en)       busy_left <= 3;
    else if (busy_left > 0) busy_left <= busy_left - 1;
    if (rst)                  b_busy_left <= 0;
    else if (b_step_en)       b_busy_left <= 3;
    else if (b_busy_left > 0) b_busy_left <= b_busy_left - 1;
  end

  logic [7:0]  txq[$];
  logic [4:0]  wr_rows[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  b_txq[$];
  logic [2:0]  b_wr_rows[$];
  logic [12:0] b_wr_data[$];
  int steps = 0, step_viol = 0, stall_viol = 0, b_steps = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (stall_prev && tx_data !== stall_data) stall_viol <= stall_viol + 1;
    stall_prev <= tx_valid && !tx_ready;
    stall_data <= tx_data;
    if (row_wr_en) begin wr_rows.push_back(row_sel); wr_data.push_back(row_wr_data); end
    if (step_en) steps <= steps + 1;
    if (step_en && grid_busy) step_viol <= step_viol + 1;
    if (b_tx_valid && b_tx_ready) b_txq.push_back(b_tx_data);
    if (b_row_wr_en) begin b_wr_rows.push_back(b_row_sel); b_wr_data.push_back(b_row_wr_data); end
    if (b_step_en) b_steps <= b_steps + 1;
  end

  task automatic send_byte(input bit to_b, input logic [7:0] b, input int limit);
    int n;
    @(negedge clk);
    if (to_b) begin b_rx_data = b; b_rx_valid = 1'b1; end
    else begin rx_data = b; rx_valid = 1'b1; end
    @(negedge clk);
    rx_valid = 1'b0;
    b_rx_valid = 1'b0;
    n = 0;
    while ((to_b ? b_busy : busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send_str(input bit to_b, input string s, input int limit);
    for (int i = 0; i < s.len(); i++) send_byte(to_b, s[i], limit);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; b_rx_valid = 1'b0; b_rx_data = 8'h00;
    ready_fixed = 1'b1; ready_random = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
    vectors++; if (row_sel !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_row_sel got %0d want 0", row_sel); end
    vectors++; if (row_wr_data !== 8'h00 || row_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_row_wr got en=%b data=%h want 0/00", row_wr_en, row_wr_data); end
    vectors++; if (step_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_step_en got %b want 0", step_en); end
    vectors++; if (busy !== 1'b0 || rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy_overrun got %b/%b want 0/0", busy, rx_overrun); end
    vectors++; if (b_busy !== 1'b0 || b_tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_b got busy=%b tx_valid=%b want 0/0", b_busy, b_tx_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_row_write;
    int bad;
    txq.delete(); wr_rows.delete(); wr_data.delete();
    send_byte(1'b0, "w", 50);
    for (int i = 0; i < 256; i++) send_byte(1'b0, (i % 2 == 0) ? 8'h23 : 8'h2E, 50);
    vectors++; if (wr_rows.size() != 32) begin miscompares++; $display("[TB] FAIL write_count got %0d want 32", wr_rows.size()); end
    bad = 0;
    for (int i = 0; i < wr_rows.size(); i++) if (wr_rows[i] !== 5'(i) || wr_data[i] !== 8'h55) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL write_rows got %0d bad rows want 0", bad); end
    vectors++; if (txq.size() != 257) begin miscompares++; $display("[TB] FAIL write_echo_count got %0d want 257", txq.size()); end
    bad = 0;
    if (txq.size() == 257) begin
      if (txq[0] !== "W") bad++;
      for (int i = 0; i < 256; i++) if (txq[i+1] !== ((i % 2 == 0) ? 8'h23 : 8'h2E)) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL write_echo_bytes got %0d bad want 0", bad); end
  endtask

  task automatic test_step;
    int base;
    base = steps; txq.delete();
    send_str(1'b0, "12s", 2000);
    vectors++; if (steps - base != 12) begin miscompares++; $display("[TB] FAIL step_count got %0d want 12", steps - base); end
    vectors++; if (step_viol != 0) begin miscompares++; $display("[TB] FAIL step_while_busy got %0d want 0", step_viol); end
    vectors++; if (txq.size() != 1 || txq[0] !== "S") begin miscompares++; $display("[TB] FAIL step_echo got %0d bytes first %h want 1 byte 53", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx); end
  endtask

  task automatic test_dump_random;
    int bad, sbase;
    string row3;
    logic [7:0] e;
    send_byte(1'b0, "w", 50);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 8; c++) send_byte(1'b0, r[c] ? 8'h23 : 8'h2E, 50);
    txq.delete(); sbase = stall_viol;
    ready_random = 1'b1;
    send_byte(1'b0, "r", 20000);
    ready_random = 1'b0;
    vectors++; if (busy !== 1'b0 || txq.size() != 320) begin miscompares++; $display("[TB] FAIL dump_len got %0d bytes busy=%b want 320/0", txq.size(), busy); end
    row3 = "##......\r\n";
    bad = 0;
    if (txq.size() == 320) for (int k = 0; k < 10; k++) if (txq[30+k] !== row3[k]) bad++;
    vectors++; if (bad != 0 || txq.size() != 320) begin miscompares++; $display("[TB] FAIL dump_row3 got %0d bad chars want 0", bad); end
    bad = 0;
    if (txq.size() == 320)
      for (int r = 0; r < 32; r++)
        for (int k = 0; k < 10; k++) begin
          e = (k == 8) ? 8'h0D : (k == 9) ? 8'h0A : (r[k] ? 8'h23 : 8'h2E);
          if (txq[r*10+k] !== e) bad++;
        end
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL dump_all got %0d bad chars want 0", bad); end
    vectors++; if (stall_viol - sbase != 0) begin miscompares++; $display("[TB] FAIL dump_stall_stable got %0d changes want 0", stall_viol - sbase); end
    vectors++; if (row_sel !== 5'd0) begin miscompares++; $display("[TB] FAIL dump_row_sel_end got %0d want 0", row_sel); end
  endtask

  task automatic test_clear;
    int bad, wbase;
    txq.delete(); wbase = wr_rows.size();
    send_byte(1'b0, "c", 200);
    send_byte(1'b0, "r", 2000);
    vectors++; if (wr_rows.size() - wbase != 32) begin miscompares++; $display("[TB] FAIL clear_writes got %0d want 32", wr_rows.size() - wbase); end
    vectors++; if (txq.size() != 321 || txq[0] !== "C") begin miscompares++; $display("[TB] FAIL clear_echo got %0d bytes want 321 starting with C", txq.size()); end
    bad = 0;
    if (txq.size() == 321)
      for (int i = 0; i < 320; i++)
        if (txq[i+1] !== (((i % 10) == 8) ? 8'h0D : ((i % 10) == 9) ? 8'h0A : 8'h2E)) bad++;
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL clear_dump got %0d bad chars want 0", bad); end
  endtask

  task automatic test_misc;
    int base;
    txq.delete(); base = steps;
    send_str(1'b0, "z5zs", 500);
    vectors++; if (txq.size() != 3 || txq[0] !== "X" || txq[2] !== "S") begin miscompares++; $display("[TB] FAIL other_echo got %0d bytes want X X S", txq.size()); end
    vectors++; if (steps - base != 1) begin miscompares++; $display("[TB] FAIL count_cleared got %0d steps want 1", steps - base); end
    base = steps;
    send_str(1'b0, "3R", 3000);
    vectors++; if (steps - base != 1) begin miscompares++; $display("[TB] FAIL R_step got %0d steps want 1", steps - base); end
    vectors++; if (txq.size() != 323 || txq[3] !== 8'h2E) begin miscompares++; $display("[TB] FAIL R_dump got %0d bytes want 323 starting with '.'", txq.size()); end
  endtask

  task automatic test_overrun_reset;
    int base, n;
    txq.delete(); base = steps;
    send_byte(1'b0, "r", 0);
    repeat (10) @(negedge clk);
    send_byte(1'b0, "s", 2000);
    vectors++; if (rx_overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_flag got %b want 1", rx_overrun); end
    vectors++; if (steps != base || txq.size() != 320) begin miscompares++; $display("[TB] FAIL overrun_dump got %0d steps %0d bytes want 0/320", steps - base, txq.size()); end
    send_byte(1'b0, "r", 0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (tx_valid !== 1'b0 || rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_dump got tx_valid=%b overrun=%b want 0/0", tx_valid, rx_overrun); end
    rst = 1'b0;
    n = txq.size();
    repeat (30) @(negedge clk);
    vectors++; if (txq.size() != n || tx_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_quiet got %0d extra bytes busy=%b want 0/0", txq.size() - n, busy); end
  endtask

  task automatic test_saturation_b;
    b_txq.delete();
    send_str(1'b1, "999999s", 5000);
    vectors++; if (b_steps != 255) begin miscompares++; $display("[TB] FAIL b_saturate got %0d steps want 255", b_steps); end
    vectors++; if (b_txq.size() != 1 || b_txq[0] !== "S") begin miscompares++; $display("[TB] FAIL b_step_echo got %0d bytes want 1 S", b_txq.size()); end
  endtask

  task automatic test_wrap_b;
    int bad;
    b_wr_rows.delete(); b_wr_data.delete();
    send_byte(1'b1, "w", 50);
    for (int i = 0; i < 65; i++) send_byte(1'b1, ((i % 13) == 0) ? 8'h23 : 8'h2E, 50);
    vectors++; if (b_wr_rows.size() != 5) begin miscompares++; $display("[TB] FAIL b_write_count got %0d want 5", b_wr_rows.size()); end
    for (int i = 0; i < 13; i++) send_byte(1'b1, 8'h23, 50);
    bad = 0;
    if (b_wr_rows.size() == 6) begin
      for (int i = 0; i < 5; i++) if (b_wr_rows[i] !== 3'(i) || b_wr_data[i] !== 13'h0001) bad++;
      if (b_wr_rows[5] !== 3'd0 || b_wr_data[5] !== 13'h1FFF) bad++;
    end else bad = 99;
    vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL b_write_wrap got %0d bad writes want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_row_write();
    test_step();
    test_dump_random();
    test_clear();
    test_misc();
    test_overrun_reset();
    test_saturation_b();
    test_wrap_b();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_grid_bridge.md
# uart_grid_bridge

Parametrised UART command bridge between the host serial link and a row-addressed cellular-automaton grid engine. It decodes single-byte ASCII commands from a UART receiver, steps the engine (with an optional decimal repeat count), writes cells row by row, clears the grid, and streams the grid back as '#'/'.' text rows. It is the generalised replacement for the fixed 8×32 FPGA command loop and sits between the uart_rx/uart_tx byte interfaces and the grid core.

## Interface
- COLS, 8: cells per row; legal range 1..64.
- ROWS, 32: rows in grid; legal range 2..256. Localparam ROW_W = $clog2(ROWS).
- CNT_W, 8: width of the step-repeat counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid this cycle.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- row_sel  out  ROW_W  grid row address for read and write.
- row_rd_data  in  COLS  row contents; bit i = column i. Valid 1 cycle after row_sel changes.
- row_wr_data  out  COLS  row to write.
- row_wr_en  out  1  one-cycle write strobe for row_sel.
- step_en  out  1  one-cycle generation-step strobe.
- grid_busy  in  1  engine busy computing a generation.
- busy  out  1  bridge executing a multi-cycle command; rx bytes are not accepted.
- rx_overrun  out  1  sticky: a byte arrived while busy and was dropped.

## Operation
- States: IDLE, STEP, STEP_WAIT, DUMP_ADDR, DUMP_CELL, DUMP_CR, DUMP_LF, CLEAR, ECHO. busy = (state != IDLE) || tx_valid.
- Digits '0'..'9' in IDLE: count <= count*10 + digit, saturating at 2^CNT_W-1; no echo.
- 's'/'S': n = count (0 treated as 1); n step_en pulses, each issued only after grid_busy is low for the previous one; then echo 'S'; count cleared.
- 'r': dump from row 0. 'R': one step (count ignored), then dump. Dump per row: COLS chars, column 0 first ('#' if bit set, else '.'), then CR (0x0D), LF (0x0A). After row ROWS-1's LF return to IDLE; row_sel left at 0.
- 'w'/'W': write pointer <= row 0, col 0; echo 'W'.
- '.'/'#': write_buf[col] <= (byte=='#'); echo byte. When col==COLS-1: row_wr_en pulse with full row, col <= 0, row advances, wrapping ROWS-1 -> 0. Writes are buffered and do not make busy assert except for the echo.
- 'c'/'C': CLEAR writes zero to rows 0..ROWS-1, one per cycle; write pointer reset to row 0, col 0; echo 'C'.
- Any other byte: echo 'X'; count cleared. Digit accumulation is cleared by every non-digit byte.
- rx_valid while busy: byte dropped, rx_overrun <= 1 (cleared only by rst).

## Timing
- Reset values: tx_valid 0, tx_data 0x00, row_sel 0, row_wr_data 0, row_wr_en 0, step_en 0, busy 0, rx_overrun 0; count, write pointer and buffer 0; state IDLE. Reset mid-dump or mid-step aborts immediately; no further strobes.
- Echo: tx_valid rises the cycle after the accepting rx_valid (or after the final command action); tx_data stable while tx_valid && !tx_ready; tx_valid drops the cycle after the handshake.
- Step: step_en high exactly 1 cycle; STEP_WAIT ignores grid_busy on the cycle following step_en, then waits for grid_busy==0.
- Dump: DUMP_ADDR drives row_sel, waits 1 cycle, then latches row_rd_data; chars issued back-to-back, one per tx handshake. Total bytes = ROWS*(COLS+2).
- Row write: row_wr_en asserted the cycle after the COLS-th cell byte, with row_sel = current write row.
- CLEAR: ROWS cycles of row_wr_en, then echo.

## Test plan
- Reset, tx_ready=1, send "w" then 256 alternating '#','.' (COLS=8, ROWS=32) -> 32 row_wr_en pulses, each row_wr_data=0x55, row_sel 0..31, 257 echoes.
- Send "12s", engine model holds grid_busy 3 cycles per step -> exactly 12 step_en pulses, none while grid_busy, then single 'S'.
- Preload rows with row i = i; send "r" with tx_ready toggling randomly -> 320 bytes, row 3 = "##......\r\n", tx_data never changes while stalled.
- Send "c" then "r" -> 32 rows of "........\r\n", echo 'C' before dump.
- During dump send "s" -> no step_en, rx_overrun=1, dump completes; assert rst mid-dump -> tx_valid=0 next cycle, rx_overrun=0.
- COLS=13, ROWS=5: send "999999s" -> 255 steps (saturation); "w"+65 cells -> 5 writes, 6th row wraps to row 0.
